// File: rtl/lab_pkg.sv
// Shared definitions for the rgb-lab pipeline: channel width, multiplier latency,
// framing FSM states and the threshold-set record.
package lab_pkg;

    localparam int DSIZE      = 8;
    localparam int LATENCY    = 4;
    localparam int SAT_OFFSET = 2 ** (DSIZE - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [DSIZE-1:0] l_min;
        logic [DSIZE-1:0] l_max;
        logic [DSIZE-1:0] a_min;
        logic [DSIZE-1:0] a_max;
        logic [DSIZE-1:0] b_min;
        logic [DSIZE-1:0] b_max;
    } thr_t;

    localparam logic [DSIZE-1:0] DMAX = '1;

    localparam thr_t THR_RESET = '{
        l_min: '0, l_max: DMAX,
        a_min: '0, a_max: DMAX,
        b_min: '0, b_max: DMAX
    };

endpackage

// File: rtl/lab_threshold_mask_if.sv
// Pixel, threshold and mask/count signals between the lab matrix stage and the
// threshold-mask block; master drives pixels and thresholds, slave is the block.
interface lab_threshold_mask_if #(
    parameter int CNT_W = 20
) ();
    import lab_pkg::*;

    logic             in_valid;
    logic             in_sof;
    logic             in_eof;
    logic [DSIZE:0]   Li;
    logic [DSIZE:0]   Ai;
    logic [DSIZE:0]   Bi;
    logic [DSIZE-1:0] l_min;
    logic [DSIZE-1:0] l_max;
    logic [DSIZE-1:0] a_min;
    logic [DSIZE-1:0] a_max;
    logic [DSIZE-1:0] b_min;
    logic [DSIZE-1:0] b_max;

    logic             pix_valid;
    logic [DSIZE-1:0] Lo;
    logic [DSIZE-1:0] Ao;
    logic [DSIZE-1:0] Bo;
    logic             mask_valid;
    logic             mask;
    logic             mask_sof;
    logic             mask_eof;
    logic             frame_done;
    logic [CNT_W-1:0] match_count;

    modport master (
        output in_valid, in_sof, in_eof, Li, Ai, Bi,
               l_min, l_max, a_min, a_max, b_min, b_max,
        input  pix_valid, Lo, Ao, Bo, mask_valid, mask, mask_sof, mask_eof,
               frame_done, match_count
    );

    modport slave (
        input  in_valid, in_sof, in_eof, Li, Ai, Bi,
               l_min, l_max, a_min, a_max, b_min, b_max,
        output pix_valid, Lo, Ao, Bo, mask_valid, mask, mask_sof, mask_eof,
               frame_done, match_count
    );

endinterface

// File: rtl/lab_saturate.sv
// Combinational clamp of a two's-complement channel to unsigned DSIZE bits,
// optionally re-centred by +2^(DSIZE-1) first (used for the a/b chroma channels).
module lab_saturate
    import lab_pkg::*;
(
    input  logic [DSIZE:0]   x_i,
    input  logic             offset_en_i,
    output logic [DSIZE-1:0] y_o
);

    localparam int EW = DSIZE + 2;
    localparam logic [EW-1:0] OFFS = EW'(SAT_OFFSET);

    logic [EW-1:0] sum;

    // Two extra bits hold both the sign and the overflow past 2^DSIZE-1.
    assign sum = {x_i[DSIZE], x_i} + (offset_en_i ? OFFS : '0);

    always_comb begin
        y_o = sum[DSIZE-1:0];
        if (sum[EW-1]) begin
            y_o = '0;
        end else if (sum[DSIZE]) begin
            y_o = '1;
        end
    end

endmodule

// File: rtl/lab_threshold_mask.sv
// Re-aligns framing with the matrix latency, clamps L/a/b to 8 bits, and builds a
// frame-coherent box-threshold colour mask plus a per-frame matched-pixel count.
//
// state    | meaning
// IDLE     | between frames; pixels are masked but not counted
// IN_FRAME | sof seen; counting matched pixels until eof
module lab_threshold_mask
    import lab_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input logic              clock,
    input logic              rst,
    lab_threshold_mask_if.slave io
);

    logic [LATENCY-1:0] vld_q, sof_q, eof_q;
    logic [DSIZE-1:0]   l_sat, a_sat, b_sat;

    logic               pix_valid_q, s1_sof_q, s1_eof_q;
    logic [DSIZE-1:0]   lo_q, ao_q, bo_q;

    frame_state_e       state_q;
    thr_t               thr_q, thr_live, thr_use;
    logic [CNT_W-1:0]   cnt_q, cnt_inc, match_q;
    logic               mask_valid_q, mask_q, mask_sof_q, mask_eof_q, frame_done_q;
    logic               in_box;

    always_ff @(posedge clock) begin
        if (rst) begin
            vld_q <= '0;
            sof_q <= '0;
            eof_q <= '0;
        end else begin
            vld_q <= {vld_q[LATENCY-2:0], io.in_valid};
            sof_q <= {sof_q[LATENCY-2:0], io.in_valid & io.in_sof};
            eof_q <= {eof_q[LATENCY-2:0], io.in_valid & io.in_eof};
        end
    end

    lab_saturate u_sat_l (.x_i(io.Li), .offset_en_i(1'b0), .y_o(l_sat));
    lab_saturate u_sat_a (.x_i(io.Ai), .offset_en_i(1'b1), .y_o(a_sat));
    lab_saturate u_sat_b (.x_i(io.Bi), .offset_en_i(1'b1), .y_o(b_sat));

    always_ff @(posedge clock) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            lo_q        <= '0;
            ao_q        <= '0;
            bo_q        <= '0;
        end else begin
            pix_valid_q <= vld_q[LATENCY-1];
            s1_sof_q    <= sof_q[LATENCY-1];
            s1_eof_q    <= eof_q[LATENCY-1];
            lo_q        <= l_sat;
            ao_q        <= a_sat;
            bo_q        <= b_sat;
        end
    end

    assign thr_live = '{
        l_min: io.l_min, l_max: io.l_max,
        a_min: io.a_min, a_max: io.a_max,
        b_min: io.b_min, b_max: io.b_max
    };

    // The sof pixel itself already sees the thresholds it latches.
    assign thr_use = (pix_valid_q && s1_sof_q) ? thr_live : thr_q;

    assign in_box = (thr_use.l_min <= lo_q) && (lo_q <= thr_use.l_max) &&
                    (thr_use.a_min <= ao_q) && (ao_q <= thr_use.a_max) &&
                    (thr_use.b_min <= bo_q) && (bo_q <= thr_use.b_max);

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(in_box);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            thr_q        <= THR_RESET;
            cnt_q        <= '0;
            match_q      <= '0;
            frame_done_q <= 1'b0;
            mask_valid_q <= 1'b0;
            mask_q       <= 1'b0;
            mask_sof_q   <= 1'b0;
            mask_eof_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            mask_valid_q <= pix_valid_q;
            mask_q       <= pix_valid_q & in_box;
            mask_sof_q   <= pix_valid_q & s1_sof_q;
            mask_eof_q   <= pix_valid_q & s1_eof_q;
            if (pix_valid_q && s1_sof_q) begin
                thr_q <= thr_live;
            end
            if (pix_valid_q) begin
                if (s1_sof_q && s1_eof_q) begin
                    match_q      <= CNT_W'(in_box);
                    frame_done_q <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= IDLE;
                end else if (s1_sof_q) begin
                    cnt_q   <= CNT_W'(in_box);
                    state_q <= IN_FRAME;
                end else if (state_q == IN_FRAME) begin
                    if (s1_eof_q) begin
                        match_q      <= cnt_inc;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            end
        end
    end

    assign io.pix_valid   = pix_valid_q;
    assign io.Lo          = lo_q;
    assign io.Ao          = ao_q;
    assign io.Bo          = bo_q;
    assign io.mask_valid  = mask_valid_q;
    assign io.mask        = mask_q;
    assign io.mask_sof    = mask_sof_q;
    assign io.mask_eof    = mask_eof_q;
    assign io.frame_done  = frame_done_q;
    assign io.match_count = match_q;

endmodule

// File: tb/tb_lab_threshold_mask.sv
// Bench for lab_threshold_mask: per-cycle reference model over a pixel history,
// a single-pixel vector table, and directed multi-cycle framing sequences.
module tb_lab_threshold_mask;
    import lab_pkg::*;

    localparam int CNT_W   = 20;
    localparam int MAXC    = 4096;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    lab_threshold_mask_if #(.CNT_W(CNT_W)) io ();

    lab_threshold_mask #(.CNT_W(CNT_W)) dut (
        .clock(clock),
        .rst  (rst),
        .io   (io)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit hv[MAXC], hs[MAXC], he[MAXC];
    int hL[MAXC], hA[MAXC], hB[MAXC];
    int thr_h[MAXC][6];

    bit ob_pv[MAXC], ob_mv[MAXC], ob_mask[MAXC], ob_fd[MAXC];
    int ob_Lo[MAXC], ob_Ao[MAXC], ob_Bo[MAXC], ob_mc[MAXC];

    bit m_in_frame;
    int m_cnt, m_match;
    int m_thr[6];

    typedef struct {
        int L, A, B;
        int lmin, lmax, amin, amax, bmin, bmax;
        int eLo, eAo, eBo, em;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_l(int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int clamp_ab(int x);
        int y;
        y = x + 128;
        if (y < 0) return 0;
        if (y > 255) return 255;
        return y;
    endfunction

    function automatic bit inbox(int l, int a, int b);
        return (m_thr[0] <= l) && (l <= m_thr[1]) &&
               (m_thr[2] <= a) && (a <= m_thr[3]) &&
               (m_thr[4] <= b) && (b <= m_thr[5]);
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_cnt      = 0;
        m_match    = 0;
        m_thr      = '{0, 255, 0, 255, 0, 255};
    endtask

    // Outputs visible now belong to cycle k+1: pixel k-4 at S1, pixel k-5 at S2.
    task automatic model_check(bit r);
        int k, j;
        bit ev, mv, sof, eof, m, fd;
        k = cyc;
        if (r) begin
            model_reset();
            chk("rst_pix_valid", int'(io.pix_valid), 0);
            chk("rst_mask_valid", int'(io.mask_valid), 0);
            chk("rst_frame_done", int'(io.frame_done), 0);
            chk("rst_match_count", int'(io.match_count), 0);
            return;
        end
        ev = (k >= 4) ? hv[k-4] : 1'b0;
        chk("pix_valid", int'(io.pix_valid), int'(ev));
        if (ev) begin
            chk("Lo", int'(io.Lo), clamp_l(hL[k-4]));
            chk("Ao", int'(io.Ao), clamp_ab(hA[k-4]));
            chk("Bo", int'(io.Bo), clamp_ab(hB[k-4]));
        end
        j   = k - 5;
        mv  = (j >= 0) && hv[j];
        sof = mv && hs[j];
        eof = mv && he[j];
        fd  = 1'b0;
        chk("mask_valid", int'(io.mask_valid), int'(mv));
        chk("mask_sof", int'(io.mask_sof), int'(sof));
        chk("mask_eof", int'(io.mask_eof), int'(eof));
        if (mv) begin
            if (sof) begin
                for (int t = 0; t < 6; t++) m_thr[t] = thr_h[k][t];
            end
            m = inbox(clamp_l(hL[j]), clamp_ab(hA[j]), clamp_ab(hB[j]));
            chk("mask", int'(io.mask), int'(m));
            if (sof && eof) begin
                m_match = m; fd = 1'b1; m_in_frame = 1'b0;
            end else if (sof) begin
                m_in_frame = 1'b1; m_cnt = m;
            end else if (m_in_frame) begin
                if (eof) begin
                    m_match = (m_cnt + m > CNT_MAX) ? CNT_MAX : m_cnt + m;
                    fd = 1'b1; m_in_frame = 1'b0;
                end else begin
                    m_cnt = (m_cnt + m > CNT_MAX) ? CNT_MAX : m_cnt + m;
                end
            end
        end
        chk("frame_done", int'(io.frame_done), int'(fd));
        chk("match_count", int'(io.match_count), m_match);
    endtask

    task automatic cycle(bit v, bit s, bit e, int L, int A, int B, bit r);
        hv[cyc] = v; hs[cyc] = s; he[cyc] = e;
        hL[cyc] = L; hA[cyc] = A; hB[cyc] = B;
        io.in_valid = v; io.in_sof = s; io.in_eof = e;
        rst = r;
        io.Li = (cyc >= 4) ? 9'(hL[cyc-4]) : '0;
        io.Ai = (cyc >= 4) ? 9'(hA[cyc-4]) : '0;
        io.Bi = (cyc >= 4) ? 9'(hB[cyc-4]) : '0;
        thr_h[cyc] = '{int'(io.l_min), int'(io.l_max), int'(io.a_min),
                       int'(io.a_max), int'(io.b_min), int'(io.b_max)};
        @(posedge clock);
        #1;
        if (r) begin
            for (int j = (cyc >= 6) ? cyc - 6 : 0; j <= cyc; j++) hv[j] = 1'b0;
        end
        model_check(r);
        ob_pv[cyc+1] = io.pix_valid;  ob_mv[cyc+1] = io.mask_valid;
        ob_mask[cyc+1] = io.mask;     ob_fd[cyc+1] = io.frame_done;
        ob_Lo[cyc+1] = int'(io.Lo);   ob_Ao[cyc+1] = int'(io.Ao);
        ob_Bo[cyc+1] = int'(io.Bo);   ob_mc[cyc+1] = int'(io.match_count);
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic pix(bit s, bit e, int L, int A, int B);
        cycle(1'b1, s, e, L, A, B, 1'b0);
    endtask

    task automatic set_thr(int lmin, int lmax, int amin, int amax, int bmin, int bmax);
        io.l_min = 8'(lmin); io.l_max = 8'(lmax);
        io.a_min = 8'(amin); io.a_max = 8'(amax);
        io.b_min = 8'(bmin); io.b_max = 8'(bmax);
    endtask

    function automatic int sum_fd(int a, int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += ob_fd[i];
        return s;
    endfunction

    function automatic int sum_mask(int a, int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += (ob_mv[i] && ob_mask[i]) ? 1 : 0;
        return s;
    endfunction

    int bxL[10] = '{49, 60, 150, 151, 100, 100, 100, -5, 140, 200};
    int bxA[10] = '{0, -20, 0, 0, 13, 10, -29, 0, -28, 0};
    int bxB[10] = '{0, 0, 0, 0, 0, -50, 0, 0, 100, 0};

    initial begin
        int c0, c1, r0;
        tbl[0]  = '{100, -20, 30, 0, 255, 0, 255, 0, 255, 100, 108, 158, 1};
        tbl[1]  = '{-5, -200, 200, 0, 255, 0, 255, 0, 255, 0, 0, 255, 1};
        tbl[2]  = '{150, 0, 0, 50, 150, 100, 140, 0, 255, 150, 128, 128, 1};
        tbl[3]  = '{151, 0, 0, 50, 150, 100, 140, 0, 255, 151, 128, 128, 0};
        tbl[4]  = '{50, 12, -128, 50, 150, 100, 140, 0, 255, 50, 140, 0, 1};
        tbl[5]  = '{49, 12, 0, 50, 150, 100, 140, 0, 255, 49, 140, 128, 0};
        tbl[6]  = '{100, -29, 0, 50, 150, 100, 140, 0, 255, 100, 99, 128, 0};
        tbl[7]  = '{100, -28, 0, 50, 150, 100, 140, 0, 255, 100, 100, 128, 1};
        tbl[8]  = '{255, 127, 127, 0, 255, 0, 255, 0, 255, 255, 255, 255, 1};
        tbl[9]  = '{-256, -256, -129, 0, 255, 0, 255, 0, 255, 0, 0, 0, 1};
        tbl[10] = '{100, 0, 0, 0, 255, 200, 100, 0, 255, 100, 128, 128, 0};
        tbl[11] = '{80, 13, 0, 50, 150, 100, 140, 0, 255, 80, 141, 128, 0};

        io.in_valid = 1'b0; io.in_sof = 1'b0; io.in_eof = 1'b0;
        io.Li = '0; io.Ai = '0; io.Bi = '0;
        set_thr(0, 255, 0, 255, 0, 255);
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        idle(2);

        // single-pixel frames: alignment, saturation and threshold boundaries
        foreach (tbl[i]) begin
            set_thr(tbl[i].lmin, tbl[i].lmax, tbl[i].amin, tbl[i].amax, tbl[i].bmin, tbl[i].bmax);
            idle(2);
            c0 = cyc;
            pix(1'b1, 1'b1, tbl[i].L, tbl[i].A, tbl[i].B);
            idle(7);
            chk("tbl_pv_early", int'(ob_pv[c0+4]), 0);
            chk("tbl_pv", int'(ob_pv[c0+5]), 1);
            chk("tbl_Lo", ob_Lo[c0+5], tbl[i].eLo);
            chk("tbl_Ao", ob_Ao[c0+5], tbl[i].eAo);
            chk("tbl_Bo", ob_Bo[c0+5], tbl[i].eBo);
            chk("tbl_mask", int'(ob_mask[c0+6]), tbl[i].em);
            chk("tbl_frame_done", int'(ob_fd[c0+6]), 1);
            chk("tbl_match", ob_mc[c0+6], tbl[i].em);
        end

        // 10-pixel frame, 4 inside the box
        set_thr(50, 150, 100, 140, 0, 255);
        idle(6);
        c0 = cyc;
        for (int i = 0; i < 10; i++) pix(i == 0, i == 9, bxL[i], bxA[i], bxB[i]);
        idle(8);
        chk("box_L150_mask", int'(ob_mask[c0+2+6]), 1);
        chk("box_match", ob_mc[c0+9+6], 4);
        chk("box_done_count", sum_fd(c0, c0 + 17), 1);

        // threshold change mid-frame affects only the next frame
        set_thr(0, 255, 0, 255, 0, 255);
        idle(6);
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) io.l_min = 8'd200;
            pix(i == 0, i == 9, 100, 0, 0);
        end
        idle(6);
        chk("coh_frame1", ob_mc[c0+9+6], 10);
        c1 = cyc;
        pix(1'b1, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b0, 210, 0, 0);
        pix(1'b0, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b0, 220, 0, 0);
        pix(1'b0, 1'b1, 100, 0, 0);
        idle(7);
        chk("coh_frame2", ob_mc[c1+4+6], 2);

        // aborted frame: second sof restarts the count
        set_thr(0, 200, 0, 255, 0, 255);
        idle(6);
        c0 = cyc;
        pix(1'b1, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b0, 100, 0, 0);
        pix(1'b1, 1'b0, 250, 0, 0);
        pix(1'b0, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b1, 100, 0, 0);
        idle(8);
        chk("abort_match", ob_mc[c0+5+6], 2);
        chk("abort_done_count", sum_fd(c0, c0 + 13), 1);

        // reset mid-frame, then a pixel right as reset releases
        set_thr(0, 255, 0, 255, 0, 255);
        idle(6);
        c0 = cyc;
        pix(1'b1, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b0, 100, 0, 0);
        pix(1'b0, 1'b0, 100, 0, 0);
        r0 = cyc;
        cycle(1'b1, 1'b0, 1'b1, 100, 0, 0, 1'b1);
        pix(1'b1, 1'b1, 100, 0, 0);
        idle(8);
        chk("rst_pv_next", int'(ob_pv[r0+1]), 0);
        chk("rst_mv_next", int'(ob_mv[r0+1]), 0);
        chk("rst_mc_next", ob_mc[r0+1], 0);
        chk("rst_no_done", sum_fd(c0, r0 + 6), 0);
        chk("rst_release_done", int'(ob_fd[r0+1+6]), 1);
        chk("rst_release_match", ob_mc[r0+1+6], 1);

        // empty a-range: mask never set
        set_thr(0, 255, 200, 100, 0, 255);
        idle(6);
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            pix(i == 0, i == 7, int'($urandom_range(0, 255)), int'($urandom_range(0, 100)) - 28, 0);
        idle(8);
        chk("empty_mask_ones", sum_mask(c0, c0 + 15), 0);
        chk("empty_match", ob_mc[c0+7+6], 0);
        chk("empty_done_count", sum_fd(c0, c0 + 15), 1);

        // randomized traffic against the model
        set_thr(0, 255, 0, 255, 0, 255);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                int lm, am, bm, ax;
                lm = int'($urandom_range(0, 180));
                am = int'($urandom_range(60, 180));
                bm = int'($urandom_range(60, 180));
                ax = ($urandom_range(0, 7) == 0) ? am - 1 : am + int'($urandom_range(0, 75));
                set_thr(lm, lm + int'($urandom_range(0, 75)), am, ax, bm, bm + int'($urandom_range(0, 75)));
            end
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 200)) - 100,
                  int'($urandom_range(0, 200)) - 100, $urandom_range(0, 299) == 0);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
